// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arbiter_if : request/response channel of one ALU requester
// Rev 1.0
// ---------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      ctrl;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_zero;

  modport master (
    output req_valid, a, b, ctrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_zero
  );

  modport slave (
    input  req_valid, a, b, ctrl, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_zero
  );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_share_arbiter : round-robin sharing of one execute ALU between two ports
// Rev 1.0
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter int ALU_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  alu_share_arbiter_if.slave  r0,
  alu_share_arbiter_if.slave  r1,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  output logic [3:0]          alu_ctrl,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero,
  output logic                busy
);

  localparam int                CNT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state;
  logic             owner;
  logic             last_grant;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  rsp_data_q;
  logic             rsp_zero_q;
  logic [1:0]       rsp_valid_q;

  logic             both_valid;
  logic             any_valid;
  logic             grant;
  logic             accept;
  logic             rsp_fire;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [3:0]       req_ctrl;

  // On a tie the port that did not win last time gets the ALU.
  assign both_valid = r0.req_valid & r1.req_valid;
  assign any_valid  = r0.req_valid | r1.req_valid;
  assign grant      = both_valid ? ~last_grant : r1.req_valid;
  assign accept     = (state == S_IDLE) & any_valid & ~flush;

  assign r0.req_ready = accept & ~grant;
  assign r1.req_ready = accept &  grant;

  assign req_a    = grant ? r1.a    : r0.a;
  assign req_b    = grant ? r1.b    : r0.b;
  assign req_ctrl = grant ? r1.ctrl : r0.ctrl;

  assign r0.rsp_valid = rsp_valid_q[0];
  assign r1.rsp_valid = rsp_valid_q[1];
  assign r0.rsp_data  = rsp_data_q;
  assign r1.rsp_data  = rsp_data_q;
  assign r0.rsp_zero  = rsp_zero_q;
  assign r1.rsp_zero  = rsp_zero_q;

  assign rsp_fire = (rsp_valid_q[0] & r0.rsp_ready) | (rsp_valid_q[1] & r1.rsp_ready);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_ctrl    <= 4'b0000;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_a      <= req_a;
            alu_b      <= req_b;
            alu_ctrl   <= req_ctrl;
            owner      <= grant;
            last_grant <= grant;
            cnt        <= CNT_INIT;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (cnt == '0) begin
            rsp_data_q  <= alu_result;
            rsp_zero_q  <= alu_zero;
            rsp_valid_q <= owner ? 2'b10 : 2'b01;
            state       <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          // A flushed response is simply withdrawn; arbitration history is kept.
          if (flush || rsp_fire) begin
            rsp_valid_q <= 2'b00;
            state       <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 2'b00;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
